// File: rtl/vip_median_filter_3x3_pkg.sv
`default_nettype none
// ============================================================================
// Module : vip_median_filter_3x3_pkg
// Brief  : Shared widths, image-size defaults, pipeline latency and the sync
//          bundle type for the 3x3 median filter.
// Rev    : 1.0  initial release
// ============================================================================
package vip_median_filter_3x3_pkg;

    localparam int C_DATA_W = 8;
    localparam int C_IMG_W  = 640;
    localparam int C_IMG_H  = 480;
    localparam int C_LAT    = 3;

    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

endpackage
`default_nettype wire

// File: rtl/vip_sort3.sv
`default_nettype none
// ============================================================================
// Module : vip_sort3
// Brief  : Combinational unsigned max/mid/min of three values.
// Rev    : 1.0  initial release
// ============================================================================
module vip_sort3 #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_max,
    output logic [W-1:0] o_mid,
    output logic [W-1:0] o_min
);

    logic         w_ab;
    logic [W-1:0] w_hi;
    logic [W-1:0] w_lo;

    assign w_ab  = (i_a > i_b);
    assign w_hi  = w_ab ? i_a : i_b;
    assign w_lo  = w_ab ? i_b : i_a;

    // Ties fall through to whichever equal value is selected; both are correct.
    assign o_max = (i_c > w_hi) ? i_c : w_hi;
    assign o_min = (i_c < w_lo) ? i_c : w_lo;
    assign o_mid = (i_c > w_hi) ? w_hi : ((i_c < w_lo) ? w_lo : i_c);

endmodule
`default_nettype wire

// File: rtl/vip_median_filter_3x3.sv
`default_nettype none
// ============================================================================
// Module : vip_median_filter_3x3
// Brief  : 3-stage 3x3 median pipeline with optional centre-tap pass-through
//          on border windows and matching 3-clk sync delay.
// Rev    : 1.0  initial release
// ============================================================================
module vip_median_filter_3x3
    import vip_median_filter_3x3_pkg::*;
#(
    parameter int DATA_W    = C_DATA_W,
    parameter int IMG_W     = C_IMG_W,
    parameter int IMG_H     = C_IMG_H,
    parameter int BORDER_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              matrix_frame_vsync,
    input  logic              matrix_frame_href,
    input  logic              matrix_frame_clken,
    input  logic [DATA_W-1:0] matrix_p11,
    input  logic [DATA_W-1:0] matrix_p12,
    input  logic [DATA_W-1:0] matrix_p13,
    input  logic [DATA_W-1:0] matrix_p21,
    input  logic [DATA_W-1:0] matrix_p22,
    input  logic [DATA_W-1:0] matrix_p23,
    input  logic [DATA_W-1:0] matrix_p31,
    input  logic [DATA_W-1:0] matrix_p32,
    input  logic [DATA_W-1:0] matrix_p33,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [DATA_W-1:0] post_img_Y
);

    localparam int c_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [c_COL_W-1:0] c_COL_MAX = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_MAX = c_ROW_W'(IMG_H - 1);

    sync_t [C_LAT-1:0]  r_sync;
    sync_t              w_sync_in;
    logic [c_COL_W-1:0] r_col_cnt;
    logic [c_ROW_W-1:0] r_row_cnt;
    logic               w_vs_rise;
    logic               w_hr_fall;
    logic               w_border;

    logic [DATA_W-1:0] w_tap    [3][3];
    logic [DATA_W-1:0] w_s1_max [3];
    logic [DATA_W-1:0] w_s1_mid [3];
    logic [DATA_W-1:0] w_s1_min [3];
    logic [DATA_W-1:0] r_s1_max [3];
    logic [DATA_W-1:0] r_s1_mid [3];
    logic [DATA_W-1:0] r_s1_min [3];
    logic [DATA_W-1:0] r_s1_p22;
    logic              r_s1_border;

    logic [DATA_W-1:0] w_s2_hi;
    logic [DATA_W-1:0] w_s2_md;
    logic [DATA_W-1:0] w_s2_lo;
    logic [DATA_W-1:0] r_s2_hi;
    logic [DATA_W-1:0] r_s2_md;
    logic [DATA_W-1:0] r_s2_lo;
    logic [DATA_W-1:0] r_s2_p22;
    logic              r_s2_border;
    logic [DATA_W-1:0] w_s3_med;

    logic [DATA_W-1:0] w_unused_0, w_unused_1, w_unused_2, w_unused_3;
    logic [DATA_W-1:0] w_unused_4, w_unused_5, w_unused_6, w_unused_7;

    assign w_sync_in = {matrix_frame_vsync, matrix_frame_href, matrix_frame_clken};

    // Stage-1 sync copies double as the 1-clk history for edge detection.
    assign w_vs_rise = matrix_frame_vsync & ~r_sync[0].vsync;
    assign w_hr_fall = ~matrix_frame_href & r_sync[0].href;
    assign w_border  = (r_col_cnt < c_COL_W'(2)) || (r_row_cnt < c_ROW_W'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
            r_sync    <= '0;
        end else begin
            r_sync <= {r_sync[C_LAT-2:0], w_sync_in};
            if (!matrix_frame_href)
                r_col_cnt <= '0;
            else if (matrix_frame_clken && (r_col_cnt != c_COL_MAX))
                r_col_cnt <= r_col_cnt + c_COL_W'(1);
            if (w_vs_rise)
                r_row_cnt <= '0;
            else if (w_hr_fall && (r_row_cnt != c_ROW_MAX))
                r_row_cnt <= r_row_cnt + c_ROW_W'(1);
        end
    end

    assign w_tap[0] = '{matrix_p11, matrix_p12, matrix_p13};
    assign w_tap[1] = '{matrix_p21, matrix_p22, matrix_p23};
    assign w_tap[2] = '{matrix_p31, matrix_p32, matrix_p33};

    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        vip_sort3 #(.W(DATA_W)) u_sort_row (
            .i_a   (w_tap[gi][0]),
            .i_b   (w_tap[gi][1]),
            .i_c   (w_tap[gi][2]),
            .o_max (w_s1_max[gi]),
            .o_mid (w_s1_mid[gi]),
            .o_min (w_s1_min[gi])
        );
    end

    // Column pass over the row-sorted values leaves the true median on the anti-diagonal.
    vip_sort3 #(.W(DATA_W)) u_sort_mins (
        .i_a(r_s1_min[0]), .i_b(r_s1_min[1]), .i_c(r_s1_min[2]),
        .o_max(w_s2_hi), .o_mid(w_unused_0), .o_min(w_unused_1)
    );
    vip_sort3 #(.W(DATA_W)) u_sort_mids (
        .i_a(r_s1_mid[0]), .i_b(r_s1_mid[1]), .i_c(r_s1_mid[2]),
        .o_max(w_unused_2), .o_mid(w_s2_md), .o_min(w_unused_3)
    );
    vip_sort3 #(.W(DATA_W)) u_sort_maxs (
        .i_a(r_s1_max[0]), .i_b(r_s1_max[1]), .i_c(r_s1_max[2]),
        .o_max(w_unused_4), .o_mid(w_unused_5), .o_min(w_s2_lo)
    );
    vip_sort3 #(.W(DATA_W)) u_sort_final (
        .i_a(r_s2_hi), .i_b(r_s2_md), .i_c(r_s2_lo),
        .o_max(w_unused_6), .o_mid(w_s3_med), .o_min(w_unused_7)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_max    <= '{default: '0};
            r_s1_mid    <= '{default: '0};
            r_s1_min    <= '{default: '0};
            r_s1_p22    <= '0;
            r_s1_border <= 1'b0;
            r_s2_hi     <= '0;
            r_s2_md     <= '0;
            r_s2_lo     <= '0;
            r_s2_p22    <= '0;
            r_s2_border <= 1'b0;
            post_img_Y  <= '0;
        end else begin
            r_s1_max    <= w_s1_max;
            r_s1_mid    <= w_s1_mid;
            r_s1_min    <= w_s1_min;
            r_s1_p22    <= matrix_p22;
            r_s1_border <= w_border;
            r_s2_hi     <= w_s2_hi;
            r_s2_md     <= w_s2_md;
            r_s2_lo     <= w_s2_lo;
            r_s2_p22    <= r_s1_p22;
            r_s2_border <= r_s1_border;
            if (!r_sync[1].href)
                post_img_Y <= '0;
            else if ((BORDER_EN != 0) && r_s2_border)
                post_img_Y <= r_s2_p22;
            else
                post_img_Y <= w_s3_med;
        end
    end

    assign post_frame_vsync = r_sync[C_LAT-1].vsync;
    assign post_frame_href  = r_sync[C_LAT-1].href;
    assign post_frame_clken = r_sync[C_LAT-1].clken;

endmodule
`default_nettype wire

// File: tb/tb_vip_median_filter_3x3.sv
`default_nettype none
// ============================================================================
// Module : tb_vip_median_filter_3x3
// Brief  : Directed bench driving a BORDER_EN=1 and a BORDER_EN=0 instance
//          (IMG_W=8, IMG_H=6) with the same windows and sync.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vip_median_filter_3x3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            vs = 1'b0, hr = 1'b0, ce = 1'b0;
    logic [8:0][7:0] tp = '0;

    logic       b_vs, b_hr, b_ce, m_vs, m_hr, m_ce;
    logic [7:0] b_y, m_y;

    int vectors = 0;
    int miscompares = 0;
    int n = 0;

    // Expected outputs for the beat applied at cycle k live in slot k%4.
    logic       sl_v  [4] = '{default: 1'b0};
    logic       sl_vs [4], sl_hr [4], sl_ce [4], sl_cy [4];
    logic [7:0] sl_yb [4], sl_ym [4];

    always #5 clk = ~clk;

    vip_median_filter_3x3 #(.DATA_W(8), .IMG_W(8), .IMG_H(6), .BORDER_EN(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .matrix_frame_vsync(vs), .matrix_frame_href(hr), .matrix_frame_clken(ce),
        .matrix_p11(tp[0]), .matrix_p12(tp[1]), .matrix_p13(tp[2]),
        .matrix_p21(tp[3]), .matrix_p22(tp[4]), .matrix_p23(tp[5]),
        .matrix_p31(tp[6]), .matrix_p32(tp[7]), .matrix_p33(tp[8]),
        .post_frame_vsync(b_vs), .post_frame_href(b_hr), .post_frame_clken(b_ce),
        .post_img_Y(b_y)
    );

    vip_median_filter_3x3 #(.DATA_W(8), .IMG_W(8), .IMG_H(6), .BORDER_EN(0)) dut_m (
        .clk(clk), .rst_n(rst_n),
        .matrix_frame_vsync(vs), .matrix_frame_href(hr), .matrix_frame_clken(ce),
        .matrix_p11(tp[0]), .matrix_p12(tp[1]), .matrix_p13(tp[2]),
        .matrix_p21(tp[3]), .matrix_p22(tp[4]), .matrix_p23(tp[5]),
        .matrix_p31(tp[6]), .matrix_p32(tp[7]), .matrix_p33(tp[8]),
        .post_frame_vsync(m_vs), .post_frame_href(m_hr), .post_frame_clken(m_ce),
        .post_img_Y(m_y)
    );

    function automatic logic [7:0] med9(input logic [8:0][7:0] t);
        logic [7:0] a [9];
        logic [7:0] tmp;
        for (int i = 0; i < 9; i++) a[i] = t[i];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    tmp = a[j]; a[j] = a[j+1]; a[j+1] = tmp;
                end
        return a[4];
    endfunction

    function automatic logic [8:0][7:0] win(input logic [7:0] a, b, c, d, e, f, g, h, i);
        logic [8:0][7:0] w;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e;
        w[5] = f; w[6] = g; w[7] = h; w[8] = i;
        return w;
    endfunction

    function automatic logic [8:0][7:0] pix(input int line, input int beat);
        logic [8:0][7:0] w;
        for (int k = 0; k < 9; k++)
            w[k] = 8'((line * 29 + beat * 41 + k * k * 13 + k * 7) % 256);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d: observed %0d, expected %0d", tag, n, obs, exp);
        end
    endtask

    task automatic check_slot(input int s);
        if (sl_v[s]) begin
            chk("b.vsync", {7'd0, b_vs}, {7'd0, sl_vs[s]});
            chk("b.href",  {7'd0, b_hr}, {7'd0, sl_hr[s]});
            chk("b.clken", {7'd0, b_ce}, {7'd0, sl_ce[s]});
            chk("m.vsync", {7'd0, m_vs}, {7'd0, sl_vs[s]});
            chk("m.href",  {7'd0, m_hr}, {7'd0, sl_hr[s]});
            chk("m.clken", {7'd0, m_ce}, {7'd0, sl_ce[s]});
            if (sl_cy[s]) begin
                chk("b.Y", b_y, sl_yb[s]);
                chk("m.Y", m_y, sl_ym[s]);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".b.vsync"}, {7'd0, b_vs}, 8'd0);
        chk({tag, ".b.href"},  {7'd0, b_hr}, 8'd0);
        chk({tag, ".b.clken"}, {7'd0, b_ce}, 8'd0);
        chk({tag, ".b.Y"},     b_y,          8'd0);
        chk({tag, ".m.vsync"}, {7'd0, m_vs}, 8'd0);
        chk({tag, ".m.href"},  {7'd0, m_hr}, 8'd0);
        chk({tag, ".m.clken"}, {7'd0, m_ce}, 8'd0);
        chk({tag, ".m.Y"},     m_y,          8'd0);
    endtask

    // One clock of stimulus; bd is the border status this beat must carry.
    task automatic beat(input logic v, h, c, input logic [8:0][7:0] t, input logic bd);
        logic [7:0] md;
        int s;
        @(negedge clk);
        check_slot((n + 1) % 4);
        vs = v; hr = h; ce = c; tp = t;
        md = med9(t);
        s  = n % 4;
        sl_v[s]  = 1'b1;
        sl_vs[s] = v; sl_hr[s] = h; sl_ce[s] = c;
        sl_cy[s] = c | ~h;
        sl_ym[s] = h ? md : 8'd0;
        sl_yb[s] = h ? (bd ? t[4] : md) : 8'd0;
        n++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) beat(1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    logic [8:0][7:0] t_ord, t_salt_hi, t_salt_lo, t_c77;

    initial begin
        t_ord     = win(9, 1, 5, 3, 7, 2, 8, 4, 6);
        t_salt_hi = win(100, 100, 100, 100, 255, 100, 100, 100, 100);
        t_salt_lo = win(100, 100, 100, 100, 0, 100, 100, 100, 100);
        t_c77     = win(77, 77, 77, 77, 77, 77, 77, 77, 77);

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Constant window: no vsync yet, so every beat is a border beat.
        idle(2);
        for (int b = 0; b < 4; b++) beat(1'b0, 1'b1, 1'b1, t_c77, 1'b1);
        idle(3);

        // Frame longer and wider than IMG_H/IMG_W exercises both saturations.
        beat(1'b1, 1'b0, 1'b0, '0, 1'b1);
        idle(1);
        for (int l = 0; l < 9; l++) begin
            for (int b = 0; b < 10; b++)
                beat(1'b0, 1'b1, 1'b1, pix(l, b), (l < 2) || (b < 2));
            idle(2);
        end

        // Interior directed windows (row_cnt saturated at 5).
        beat(1'b0, 1'b1, 1'b1, pix(20, 0), 1'b1);
        beat(1'b0, 1'b1, 1'b1, pix(20, 1), 1'b1);
        beat(1'b0, 1'b1, 1'b1, t_ord,      1'b0);
        beat(1'b0, 1'b1, 1'b1, t_salt_hi,  1'b0);
        beat(1'b0, 1'b1, 1'b1, t_salt_lo,  1'b0);
        beat(1'b0, 1'b0, 1'b1, t_c77,      1'b1);
        idle(1);

        // clken 1010: column advances only on the 1s, so the second 1 is still a border beat.
        beat(1'b0, 1'b1, 1'b1, t_ord, 1'b1);
        beat(1'b0, 1'b1, 1'b0, t_ord, 1'b1);
        beat(1'b0, 1'b1, 1'b1, t_ord, 1'b1);
        beat(1'b0, 1'b1, 1'b0, t_ord, 1'b0);
        beat(1'b0, 1'b1, 1'b1, t_ord, 1'b0);
        beat(1'b0, 1'b1, 1'b0, t_ord, 1'b0);
        beat(1'b0, 1'b1, 1'b1, t_ord, 1'b0);
        beat(1'b0, 1'b1, 1'b0, t_ord, 1'b0);
        idle(2);

        // Reset in the middle of a line.
        beat(1'b0, 1'b1, 1'b1, pix(30, 0), 1'b1);
        beat(1'b0, 1'b1, 1'b1, pix(30, 1), 1'b1);
        beat(1'b0, 1'b1, 1'b1, pix(30, 2), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        vs = 1'b0; hr = 1'b0; ce = 1'b0; tp = '0;
        for (int i = 0; i < 4; i++) sl_v[i] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        idle(1);
        beat(1'b1, 1'b0, 1'b0, '0, 1'b1);
        idle(1);
        for (int l = 0; l < 4; l++) begin
            for (int b = 0; b < 5; b++)
                beat(1'b0, 1'b1, 1'b1, pix(l + 40, b), (l < 2) || (b < 2));
            idle(2);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
